load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
- REQ-001 SHALL have parameter NUM_WORDS, default 64, giving the number of 32-bit words in the attached data memory.
- REQ-002 SHALL have parameter WAIT_CYCLES, default 1, giving the extra cycles held after the memory access (0..15).
- REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
- REQ-005 SHALL have port req_valid  input  1  pipeline request present.
- REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
- REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
- REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- REQ-009 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- REQ-010 SHALL have port req_addr  input  32  byte address.
- REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned.
- REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
- REQ-013 SHALL have port resp_rdata  output  32  extended load data (0 for stores and errors).
- REQ-014 SHALL have port resp_error  output  1  request rejected; qualified by resp_valid.
- REQ-015 SHALL have ports mem_addr  output  32, mem_write_en  output  1, mem_write_size  output  2, mem_write_data  output  32, mem_read_data  input  32; these drive the data memory.

Function
- REQ-016 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
- REQ-017 SHALL assert req_ready only in IDLE; a request SHALL be accepted on a cycle with req_valid && req_ready, and all req_* fields SHALL be latched.
- REQ-018 SHALL transition IDLE->ACCESS on a legal accepted request and IDLE->RESP on an illegal one.
- REQ-019 SHALL treat these as illegal: req_size=11, or req_addr + 2^req_size > 4*NUM_WORDS (computed at 33-bit width, no wrap).
- REQ-020 SHALL drive mem_addr from the latched address, and SHALL assert mem_write_en only for exactly one cycle in ACCESS for stores.
- REQ-021 SHALL hold mem_write_en at 0 for loads and for illegal requests.
- REQ-022 SHALL transition ACCESS->WAIT when WAIT_CYCLES>0, WAIT->RESP after WAIT_CYCLES cycles, and ACCESS->RESP when WAIT_CYCLES=0.
- REQ-023 SHALL capture mem_read_data on the final ACCESS/WAIT cycle.
- REQ-024 SHALL extend loads from byte lane 0: byte uses [7:0] and half uses [15:0], sign- or zero-extended per req_unsigned; word is passed through.
- REQ-025 SHALL pulse resp_valid for one cycle in RESP, then return to IDLE.
- REQ-026 SHALL meet this latency: accept at T -> resp_valid at T+2+WAIT_CYCLES; illegal request -> resp_valid at T+1 with resp_error=1.
- REQ-027 SHALL drop a new req_valid during a busy period: it is not accepted, and it is not lost by the requester because req_ready=0.

Reset
- REQ-028 SHALL, with reset low at a clock edge, set state IDLE and force req_ready, resp_valid, resp_error, resp_rdata, mem_addr, mem_write_en, mem_write_size and mem_write_data to 0.
- REQ-029 SHALL, on reset mid-operation, abandon the transaction: no resp_valid pulse, and no further mem_write_en.
- REQ-030 SHALL assert req_ready on the first cycle after reset returns high.

Configuration
- REQ-031 SHALL support macro MISALIGN_TRAP_EN.
  - Defined: half at odd address, or word with addr[1:0]!=0, is illegal (error path of REQ-018).
  - Undefined: misaligned accesses proceed to memory unchanged.

Structure
- REQ-032 SHALL take the size encoding (SIZE_BYTE/HALF/WORD) and the FSM state enum from shared package mips_mem_pkg.
- REQ-033 SHALL place load extension in combinational sub-module load_extend.

Verification (NUM_WORDS=64, WAIT_CYCLES=1)
- REQ-034 SHALL cover: sw 0xDEADBEEF @0x10 -> mem_write_en high one cycle, mem_write_size=10, resp_valid at T+3, resp_error=0.
- REQ-035 SHALL cover: after REQ-034, lb @0x10 -> 0xFFFFFFEF; lbu @0x13 -> 0x000000DE; lh @0x12 -> 0xFFFFDEAD.
- REQ-036 SHALL cover: lw @0xFC -> OK; lw @0xFE -> resp_error=1 at T+1, mem_write_en never high.
- REQ-037 SHALL cover: req_size=11 store @0x0 -> resp_error=1, no memory write.
- REQ-038 SHALL cover: lh @0x11 -> with MISALIGN_TRAP_EN, error; without it, valid data.
- REQ-039 SHALL cover: reset low in the cycle after accept -> no resp_valid; req_ready=1 the first cycle after reset releases.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared memory-access encodings and load/store FSM state type.
package mips_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } lsu_state_t;

    // Byte count of an access; 0 for the illegal encoding.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            SIZE_WORD: size_bytes = 3'd4;
            default:   size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of lane-0 load data by access size.
module load_extend
    import mips_mem_pkg::*;
(
    input  logic [DATA_W-1:0] raw_data,
    input  logic [1:0]        size,
    input  logic              zero_ext,
    output logic [DATA_W-1:0] ext_data_c
);

    always_comb begin
        ext_data_c = raw_data;
        case (size)
            SIZE_BYTE: ext_data_c = zero_ext ? {24'b0, raw_data[7:0]}
                                             : {{24{raw_data[7]}}, raw_data[7:0]};
            SIZE_HALF: ext_data_c = zero_ext ? {16'b0, raw_data[15:0]}
                                             : {{16{raw_data[15]}}, raw_data[15:0]};
            default:   ext_data_c = raw_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with bounds checking and fixed wait states.
// Optional build macro MISALIGN_TRAP_EN rejects misaligned half/word accesses.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned NUM_WORDS   = 64,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [1:0]        mem_write_size,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [32:0]      MEM_BYTES = 33'(4 * NUM_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              zext_q, zext_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] raw_q, raw_d;

    logic              req_ready_d, resp_valid_d, resp_error_d, mem_write_en_d;
    logic [DATA_W-1:0] resp_rdata_d, mem_addr_d, mem_write_data_d;
    logic [1:0]        mem_write_size_d;

    logic [32:0]       req_end_c;
    logic              req_illegal_c;
    logic [DATA_W-1:0] ext_data_c;

    // Request legality: bad size or any byte past the end of memory (no wrap).
    always_comb begin
        req_end_c     = {1'b0, req_addr} + 33'(size_bytes(req_size));
        req_illegal_c = (req_size == SIZE_ILLEGAL) || (req_end_c > MEM_BYTES);
`ifdef MISALIGN_TRAP_EN
        if ((req_size == SIZE_HALF && req_addr[0]) ||
            (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)) begin
            req_illegal_c = 1'b1;
        end
`endif
    end

    load_extend u_load_extend (
        .raw_data   (raw_q),
        .size       (size_q),
        .zero_ext   (zext_q),
        .ext_data_c (ext_data_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        write_d          = write_q;
        size_d           = size_q;
        zext_d           = zext_q;
        err_d            = err_q;
        raw_d            = raw_q;
        resp_valid_d     = 1'b0;
        resp_error_d     = 1'b0;
        resp_rdata_d     = '0;
        mem_addr_d       = mem_addr;
        mem_write_en_d   = 1'b0;
        mem_write_size_d = mem_write_size;
        mem_write_data_d = mem_write_data;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    write_d          = req_write;
                    size_d           = req_size;
                    zext_d           = req_unsigned;
                    mem_addr_d       = req_addr;
                    mem_write_size_d = req_size;
                    mem_write_data_d = req_wdata;
                    err_d            = req_illegal_c;
                    if (req_illegal_c) begin
                        state_d = RESP;
                    end else begin
                        state_d        = ACCESS;
                        mem_write_en_d = req_write;
                    end
                end
            end
            ACCESS: begin
                if (WAIT_CYCLES == 0) begin
                    raw_d   = mem_read_data;
                    state_d = RESP;
                end else begin
                    cnt_d   = WAIT_LAST;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    raw_d   = mem_read_data;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                resp_valid_d = 1'b1;
                resp_error_d = err_q;
                resp_rdata_d = (err_q || write_q) ? '0 : ext_data_c;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            write_q        <= 1'b0;
            size_q         <= '0;
            zext_q         <= 1'b0;
            err_q          <= 1'b0;
            raw_q          <= '0;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_rdata     <= '0;
            mem_addr       <= '0;
            mem_write_en   <= 1'b0;
            mem_write_size <= '0;
            mem_write_data <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            write_q        <= write_d;
            size_q         <= size_d;
            zext_q         <= zext_d;
            err_q          <= err_d;
            raw_q          <= raw_d;
            req_ready      <= req_ready_d;
            resp_valid     <= resp_valid_d;
            resp_error     <= resp_error_d;
            resp_rdata     <= resp_rdata_d;
            mem_addr       <= mem_addr_d;
            mem_write_en   <= mem_write_en_d;
            mem_write_size <= mem_write_size_d;
            mem_write_data <= mem_write_data_d;
        end
    end

endmodule
